// File: rtl/seq_divider_if.sv
// Request/result bundle for the shared sequential divider.
// The master drives operands and START; the slave returns the registered result and status.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             SGN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             BUSY;
  logic             DONE;
  logic             DZ;
  logic             OVF;

  modport master (
    output START, SGN, A, B,
    input  Q, R, BUSY, DONE, DZ, OVF
  );

  modport slave (
    input  START, SGN, A, B,
    output Q, R, BUSY, DONE, DZ, OVF
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned per operation.
// Magnitudes are divided unsigned, then a FIX cycle restores signs and flags overflow.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] p_q, p_d;       // partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] t_diff;
  logic             carry;
  logic             no_borrow;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    sgn_d   = sgn_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    // P can exceed WIDTH bits after the shift, so its top bit also counts as "no borrow".
    p_sh             = {p_q, dvd_q[WIDTH-1]};
    {carry, t_diff}  = {1'b0, p_sh[WIDTH-1:0]} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow        = p_sh[WIDTH] | carry;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          sgn_d = bus.SGN;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (bus.B == '0) begin
            q_d    = '1;
            r_d    = bus.A;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            a_neg_d = bus.SGN & bus.A[WIDTH-1];
            b_neg_d = bus.SGN & bus.B[WIDTH-1];
            dvd_d   = a_neg_d ? neg(bus.A) : bus.A;
            dvs_d   = b_neg_d ? neg(bus.B) : bus.B;
            p_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ITER;
          end
        end
      end

      ITER: begin
        p_d   = no_borrow ? t_diff : p_sh[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        // Only -min / -1 yields a magnitude that cannot be represented with positive sign.
        q_d     = (sgn_q & (a_neg_q ^ b_neg_q)) ? neg(dvd_q) : dvd_q;
        r_d     = (sgn_q & a_neg_q) ? neg(p_q) : p_q;
        ovf_d   = sgn_q & a_neg_q & b_neg_q & dvd_q[WIDTH-1];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.DZ   = dz_q;
  assign bus.OVF  = ovf_q;

endmodule
